draw_scheduler: RTL and testbench

Per-frame sequencer and VGA write arbiter for sprite drawers such as cars, towers and lasers. On each frame tick it starts every enabled client in turn, lowest index first, so that higher indices overlay lower ones. Each client runs its start/done drawing handshake while it holds the grant, and only the granted client's pixel writes reach the single VGA write port. The block sits between the per-object drawing modules and the VGA adapter, replacing ad-hoc done-to-start chaining and priority muxing.

---
 rtl/draw_pkg.sv | 32 +++
 rtl/draw_scheduler_if.sv | 26 ++
 rtl/draw_first_set.sv | 20 ++
 rtl/draw_scheduler.sv | 152 +++++++++++++++
 tb/tb_draw_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared types and widths for the per-frame draw scheduler.
// Holds the FSM state enum and the {x, y} coordinate pack/unpack helpers.
package draw_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COORD_W  = 15;
  localparam int unsigned COLOUR_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    START,
    WAIT,
    FIN
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  function automatic logic [COORD_W-1:0] coord_pack(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

  function automatic coord_t coord_unpack(input logic [COORD_W-1:0] c);
    return coord_t'(c);
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Client handshake/pixel bus and VGA write port of the draw scheduler.
// master = scheduler side, slave = drawing clients plus VGA adapter.
interface draw_scheduler_if #(
  parameter int unsigned NUM_CLIENTS = 4
) ();

  logic [NUM_CLIENTS-1:0]                     client_start;
  logic [NUM_CLIENTS-1:0]                     client_done;
  logic [NUM_CLIENTS-1:0]                     client_wren;
  logic [NUM_CLIENTS*draw_pkg::COORD_W-1:0]   client_coord;
  logic [NUM_CLIENTS*draw_pkg::COLOUR_W-1:0]  client_colour;
  logic                                       vga_wren;
  logic [draw_pkg::COORD_W-1:0]               vga_coord;
  logic [draw_pkg::COLOUR_W-1:0]              vga_colour;

  modport master (
    output client_start, vga_wren, vga_coord, vga_colour,
    input  client_done, client_wren, client_coord, client_colour
  );

  modport slave (
    input  client_start, vga_wren, vga_coord, vga_colour,
    output client_done, client_wren, client_coord, client_colour
  );

endinterface

// File: rtl/draw_first_set.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in vec_i plus a valid flag.
module draw_first_set #(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top so the lowest set bit is written last and wins.
  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer and VGA write arbiter for sprite drawing clients.
// Optional client watchdog enabled by defining DRAW_SCHED_WDOG_EN.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned WDOG_CYCLES = 20000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic [NUM_CLIENTS-1:0] client_mask,
  draw_scheduler_if.master       bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   wdog_err
);

  localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] pending_q, pending_d;
  logic [NUM_CLIENTS-1:0] start_q, start_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   wdog_err_q, wdog_err_d;
  logic                   vga_wren_q, vga_wren_d;
  logic [COORD_W-1:0]     vga_coord_q, vga_coord_d;
  logic [COLOUR_W-1:0]    vga_colour_q, vga_colour_d;

  logic [IDX_W-1:0]       first_idx_c;
  logic                   first_vld_c;
  logic                   timeout_c;

  draw_first_set #(.W(NUM_CLIENTS), .IW(IDX_W)) u_first_set (
    .vec_i   (pending_q),
    .idx_o   (first_idx_c),
    .valid_o (first_vld_c)
  );

`ifdef DRAW_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog_cnt_q;

  // Restarts for every client; START always precedes WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                wdog_cnt_q <= '0;
    else if (state_q == START)  wdog_cnt_q <= '0;
    else if (state_q == WAIT)   wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
  end

  assign timeout_c = (state_q == WAIT) && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog_cycles;
  assign unused_wdog_cycles = ^WDOG_CYCLES;
  assign timeout_c          = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      start_q      <= '0;
      cur_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      wdog_err_q   <= 1'b0;
      vga_wren_q   <= 1'b0;
      vga_coord_q  <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      start_q      <= start_d;
      cur_q        <= cur_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      wdog_err_q   <= wdog_err_d;
      vga_wren_q   <= vga_wren_d;
      vga_coord_q  <= vga_coord_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  // Pulse outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    start_d      = '0;
    cur_d        = cur_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    wdog_err_d   = wdog_err_q;
    vga_wren_d   = 1'b0;
    vga_coord_d  = vga_coord_q;
    vga_colour_d = vga_colour_q;

    if (frame_tick && enable && (state_q != IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          pending_d = client_mask;
          state_d   = SEL;
        end
      end
      SEL: begin
        if (!first_vld_c) begin
          frame_done_d = 1'b1;
          state_d      = FIN;
        end else begin
          cur_d                  = first_idx_c;
          pending_d[first_idx_c] = 1'b0;
          start_d[first_idx_c]   = 1'b1;
          state_d                = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.client_wren[cur_q]) begin
          vga_wren_d   = 1'b1;
          vga_coord_d  = bus.client_coord[32'(cur_q) * COORD_W +: COORD_W];
          vga_colour_d = bus.client_colour[32'(cur_q) * COLOUR_W +: COLOUR_W];
        end
        if (bus.client_done[cur_q] || timeout_c) begin
          if (!bus.client_done[cur_q]) wdog_err_d = 1'b1;
          state_d = SEL;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.client_start = start_q;
  assign bus.vga_wren     = vga_wren_q;
  assign bus.vga_coord    = vga_coord_q;
  assign bus.vga_colour   = vga_colour_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign overrun          = overrun_q;
  assign wdog_err         = wdog_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus pushes expected start/VGA/frame_done
// events with hand-computed cycles, a monitor pops and compares them.
module tb_draw_scheduler;
  import draw_pkg::*;

  localparam int EV_START = 0;
  localparam int EV_VGA   = 1;
  localparam int EV_FDONE = 2;
`ifdef DRAW_SCHED_WDOG_EN
  localparam int unsigned WDOG = 50;
`else
  localparam int unsigned WDOG = 20000;
`endif

  typedef struct {
    int          kind;
    int          cyc;
    logic [23:0] data;
  } ev_t;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic       enable;
  logic [3:0] client_mask;
  logic       busy, frame_done, overrun, wdog_err;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   dly[4];
  int   done_at[4];
  logic [3:0] wr_force;
  ev_t  exp_q[$];
  int   t0;

  draw_scheduler_if #(.NUM_CLIENTS(4)) bus ();

  draw_scheduler #(.NUM_CLIENTS(4), .WDOG_CYCLES(WDOG)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .client_mask (client_mask),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .wdog_err    (wdog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL time_limit cyc=%0d required finish before limit", cyc);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [23:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [23:0] data);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected actual kind=%0d data=%h cyc=%0d required no event",
               kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
        n_err++;
        $display("FAIL sb_event actual kind=%0d cyc=%0d data=%h required kind=%0d cyc=%0d data=%h",
                 kind, cyc, data, e.kind, e.cyc, e.data);
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (bus.client_start[i] === 1'b1) sb_check(EV_START, 24'(i));
      if (bus.vga_wren === 1'b1) sb_check(EV_VGA, {bus.vga_coord, bus.vga_colour});
      if (frame_done === 1'b1) sb_check(EV_FDONE, 24'd0);
    end
  end

  // Client model: done pulse dly cycles after its start (0 = never), cycle-tagged pixel data.
  initial begin
    bus.client_done   = '0;
    bus.client_wren   = '0;
    bus.client_coord  = '0;
    bus.client_colour = '0;
    for (int i = 0; i < 4; i++) done_at[i] = -1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!resetn) done_at[i] = -1;
        else if (bus.client_start[i] === 1'b1 && dly[i] > 0) done_at[i] = cyc + dly[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        bus.client_done[i]                 = (cyc == done_at[i]);
        bus.client_wren[i]                 = wr_force[i];
        bus.client_coord[i*COORD_W +: COORD_W]    = coord_pack(8'(i * 40), 7'(cyc));
        bus.client_colour[i*COLOUR_W +: COLOUR_W] = {2'(i), 7'(cyc)};
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic do_tick(input logic [3:0] mask, output int t);
    client_mask = mask;
    frame_tick  = 1'b1;
    t           = cyc;
    next_cycle();
    frame_tick  = 1'b0;
  endtask

  function automatic logic [23:0] vga_exp(input int i, input int c);
    return {coord_pack(8'(i * 40), 7'(c)), 2'(i), 7'(c)};
  endfunction

  initial begin
    resetn      = 1'b0;
    frame_tick  = 1'b0;
    enable      = 1'b0;
    client_mask = '0;
    wr_force    = '0;
    dly         = '{10, 10, 10, 10};
    repeat (3) next_cycle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(bus.client_start), 32'd0);
    check("rst_vga", 32'({bus.vga_wren, bus.vga_coord, bus.vga_colour}), 32'd0);
    check("rst_flags", 32'({frame_done, overrun, wdog_err}), 32'd0);
    resetn = 1'b1;
    repeat (2) next_cycle();

    // All four clients, starts 12 cycles apart.
    enable = 1'b1;
    do_tick(4'b1111, t0);
    check("t1_busy", 32'(busy), 32'd1);
    push(EV_START, t0 + 2, 24'd0);
    push(EV_START, t0 + 14, 24'd1);
    push(EV_START, t0 + 26, 24'd2);
    push(EV_START, t0 + 38, 24'd3);
    push(EV_FDONE, t0 + 50, 24'd0);
    wait_until(t0 + 55);
    check("t1_idle", 32'(busy), 32'd0);

    // Tick while disabled is ignored without overrun.
    enable = 1'b0;
    do_tick(4'b1111, t0);
    wait_until(t0 + 10);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_overrun", 32'(overrun), 32'd0);
    enable = 1'b1;

    // Sparse mask; mid-frame mask change ignored.
    do_tick(4'b1010, t0);
    push(EV_START, t0 + 2, 24'd1);
    push(EV_START, t0 + 14, 24'd3);
    push(EV_FDONE, t0 + 26, 24'd0);
    wait_until(t0 + 5);
    client_mask = 4'b1111;
    wait_until(t0 + 30);

    // Client 2 granted while 0, 1, 2 all write.
    wr_force = 4'b0111;
    dly[2]   = 6;
    do_tick(4'b0100, t0);
    push(EV_START, t0 + 2, 24'd2);
    for (int k = 0; k < 6; k++) push(EV_VGA, t0 + 4 + k, vga_exp(2, t0 + 3 + k));
    push(EV_FDONE, t0 + 10, 24'd0);
    wait_until(t0 + 12);
    check("t3_wren_low", 32'(bus.vga_wren), 32'd0);
    check("t3_hold", 32'({bus.vga_coord, bus.vga_colour}), 32'(vga_exp(2, t0 + 8)));
    wr_force = '0;
    dly[2]   = 10;

    // Tick while busy sets sticky overrun; enable dropping mid-frame does not abort.
    check("t4_ovr_pre", 32'(overrun), 32'd0);
    do_tick(4'b0001, t0);
    push(EV_START, t0 + 2, 24'd0);
    push(EV_FDONE, t0 + 14, 24'd0);
    wait_until(t0 + 5);
    client_mask = 4'b1111;
    frame_tick  = 1'b1;
    next_cycle();
    frame_tick  = 1'b0;
    next_cycle();
    check("t4_ovr_set", 32'(overrun), 32'd1);
    enable = 1'b0;
    wait_until(t0 + 30);
    check("t4_ovr_sticky", 32'(overrun), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);
    enable = 1'b1;

    // Asynchronous reset while client 1 waits.
    do_tick(4'b0011, t0);
    push(EV_START, t0 + 2, 24'd0);
    push(EV_START, t0 + 14, 24'd1);
    wait_until(t0 + 18);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_flags", 32'({frame_done, overrun, wdog_err}), 32'd0);
    check("t5_outs", 32'({bus.client_start, bus.vga_wren, bus.vga_coord}), 32'd0);
    repeat (3) next_cycle();
    resetn = 1'b1;
    repeat (3) next_cycle();
    do_tick(4'b0011, t0);
    push(EV_START, t0 + 2, 24'd0);
    push(EV_START, t0 + 14, 24'd1);
    push(EV_FDONE, t0 + 26, 24'd0);
    wait_until(t0 + 30);

`ifdef DRAW_SCHED_WDOG_EN
    // Client 0 never finishes; watchdog hands over to client 1.
    dly[0] = 0;
    do_tick(4'b0011, t0);
    push(EV_START, t0 + 2, 24'd0);
    push(EV_START, t0 + 54, 24'd1);
    push(EV_FDONE, t0 + 66, 24'd0);
    wait_until(t0 + 40);
    check("t6_wdog_pre", 32'(wdog_err), 32'd0);
    wait_until(t0 + 56);
    check("t6_wdog_set", 32'(wdog_err), 32'd1);
    wait_until(t0 + 70);
    dly[0] = 10;
`else
    check("wdog_tied", 32'(wdog_err), 32'd0);
`endif

    repeat (5) next_cycle();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
